// File: rtl/midi_parser.sv
// MIDI byte-stream parser. It decodes Note On/Note Off events from a received
// byte stream, drives the LEDs with the currently held note, and flags data
// bytes that arrive with no usable status.
// Optional feature: define MIDI_RUNNING_STATUS_EN to keep the status across
// completed messages, so that further data pairs produce further events.
module midi_parser #(
    parameter logic [3:0] LISTEN_CH = 4'h0,
    parameter logic       OMNI      = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    output logic       MSG_VALID,
    output logic       NOTE_ON,
    output logic [3:0] CHANNEL,
    output logic [6:0] NOTE,
    output logic [6:0] VELOCITY,
    output logic [7:0] LED,
    output logic       ERROR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    // Running status: only note messages are ever latched here. "Invalid"
    // is represented by the IDLE state, so no separate valid flag is kept.
    logic       rs_is_on;
    logic [3:0] rs_channel;

    logic [1:0] skip_len;
    logic [1:0] skip_cnt;
    logic [6:0] note_hold;

    logic       is_realtime;
    logic       is_status;
    logic       is_note_status;
    logic       note_accept;
    logic [6:0] data_in;
    logic       event_on;

    logic       rs_load;
    logic       rs_clear;
    logic       skip_load;
    logic [1:0] skip_len_new;
    logic       skip_dec;
    logic       skip_reload;
    logic       latch_note;
    logic       fire_event;
    logic       set_error;

    assign is_realtime    = (BYTE_IN[7:3] == 5'b11111);
    assign is_status      = BYTE_IN[7];
    assign is_note_status = (BYTE_IN[7:5] == 3'b100);
    assign note_accept    = OMNI || (BYTE_IN[3:0] == LISTEN_CH);
    assign data_in        = BYTE_IN[6:0];
    assign event_on       = rs_is_on && (data_in != 7'd0);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Byte classification and next-state decode; real-time bytes fall through untouched.
    always_comb begin
        state_next   = state;
        rs_load      = 1'b0;
        rs_clear     = 1'b0;
        skip_load    = 1'b0;
        skip_len_new = 2'd2;
        skip_dec     = 1'b0;
        skip_reload  = 1'b0;
        latch_note   = 1'b0;
        fire_event   = 1'b0;
        set_error    = 1'b0;
        if (BYTE_VALID && !is_realtime) begin
            if (is_status) begin
                if (is_note_status && note_accept) begin
                    rs_load    = 1'b1;
                    state_next = WAIT_D1;
                end else if (BYTE_IN < 8'hF0) begin
                    rs_clear     = 1'b1;
                    skip_load    = 1'b1;
                    skip_len_new = (BYTE_IN[7:5] == 3'b110) ? 2'd1 : 2'd2;
                    state_next   = SKIP;
                end else begin
                    rs_clear   = 1'b1;
                    state_next = IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        set_error = 1'b1;
                    end
                    WAIT_D1: begin
                        latch_note = 1'b1;
                        state_next = WAIT_D2;
                    end
                    WAIT_D2: begin
                        fire_event = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
                        state_next = WAIT_D1;
`else
                        rs_clear   = 1'b1;
                        state_next = IDLE;
`endif
                    end
                    SKIP: begin
                        if (skip_cnt == 2'd1) begin
`ifdef MIDI_RUNNING_STATUS_EN
                            skip_reload = 1'b1;
                            state_next  = SKIP;
`else
                            state_next  = IDLE;
`endif
                        end else begin
                            skip_dec = 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    // Datapath: running status, skip counter, event outputs, LED and sticky error.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rs_is_on   <= 1'b0;
            rs_channel <= 4'd0;
            skip_len   <= 2'd2;
            skip_cnt   <= 2'd2;
            note_hold  <= 7'd0;
            MSG_VALID  <= 1'b0;
            NOTE_ON    <= 1'b0;
            CHANNEL    <= 4'd0;
            NOTE       <= 7'd0;
            VELOCITY   <= 7'd0;
            LED        <= 8'h00;
            ERROR      <= 1'b0;
        end else begin
            MSG_VALID <= fire_event;

            if (rs_load) begin
                rs_is_on   <= BYTE_IN[4];
                rs_channel <= BYTE_IN[3:0];
            end else if (rs_clear) begin
                rs_is_on   <= 1'b0;
                rs_channel <= 4'd0;
            end

            if (skip_load) begin
                skip_len <= skip_len_new;
                skip_cnt <= skip_len_new;
            end else if (skip_reload) begin
                skip_cnt <= skip_len;
            end else if (skip_dec) begin
                skip_cnt <= skip_cnt - 2'd1;
            end

            if (latch_note) begin
                note_hold <= data_in;
            end

            if (set_error) begin
                ERROR <= 1'b1;
            end

            if (fire_event) begin
                NOTE_ON  <= event_on;
                CHANNEL  <= rs_channel;
                NOTE     <= note_hold;
                VELOCITY <= data_in;
                if (event_on) begin
                    LED <= {1'b1, note_hold};
                end else if (LED[7] && (LED[6:0] == note_hold)) begin
                    LED <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Testbench for midi_parser: two instances (omni, and channel 5 only) share
// one byte stream and are compared every cycle against a message-level model.
module tb_midi_parser;

    logic       clk;
    logic       reset;
    logic [7:0] byteIn;
    logic       byteValid;

    logic [1:0] msgValid;
    logic [1:0] noteOn;
    logic [3:0] channel  [2];
    logic [6:0] note     [2];
    logic [6:0] velocity [2];
    logic [7:0] led      [2];
    logic [1:0] error;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    // Model state: the current status byte and how many data bytes it still owes.
    bit       mHasStatus [2];
    bit       mIsNote    [2];
    bit       mOnType    [2];
    bit [3:0] mCh        [2];
    int       mNeed      [2];
    int       mGot       [2];
    bit [6:0] mD1        [2];

    // Model expectations for the outputs.
    bit       eValid [2];
    bit       eOn    [2];
    bit [3:0] eCh    [2];
    bit [6:0] eNote  [2];
    bit [6:0] eVel   [2];
    bit [7:0] eLed   [2];
    bit       eErr   [2];

    midi_parser #(.LISTEN_CH(4'h0), .OMNI(1'b1)) dutOmni (
        .CLK(clk), .RESET(reset), .BYTE_IN(byteIn), .BYTE_VALID(byteValid),
        .MSG_VALID(msgValid[0]), .NOTE_ON(noteOn[0]), .CHANNEL(channel[0]),
        .NOTE(note[0]), .VELOCITY(velocity[0]), .LED(led[0]), .ERROR(error[0])
    );

    midi_parser #(.LISTEN_CH(4'h5), .OMNI(1'b0)) dutCh5 (
        .CLK(clk), .RESET(reset), .BYTE_IN(byteIn), .BYTE_VALID(byteValid),
        .MSG_VALID(msgValid[1]), .NOTE_ON(noteOn[1]), .CHANNEL(channel[1]),
        .NOTE(note[1]), .VELOCITY(velocity[1]), .LED(led[1]), .ERROR(error[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model of instance k by one clock edge's worth of input.
    task automatic modelStep(input int k, input bit rst, input bit v, input bit [7:0] b);
        bit [3:0] hi;
        bit       on;
        eValid[k] = 1'b0;
        if (rst) begin
            mHasStatus[k] = 0; mGot[k] = 0;
            mOnType[k] = 0; mCh[k] = 0; mIsNote[k] = 0; mNeed[k] = 2;
            eOn[k] = 0; eCh[k] = 0; eNote[k] = 0; eVel[k] = 0; eLed[k] = 0; eErr[k] = 0;
            return;
        end
        if (!v || b >= 8'hF8) return;
        if (b[7]) begin
            if (b < 8'hF0) begin
                hi = b[7:4];
                mHasStatus[k] = 1;
                mGot[k]       = 0;
                mCh[k]        = b[3:0];
                mOnType[k]    = (hi == 4'h9);
                mIsNote[k]    = (hi == 4'h8 || hi == 4'h9) && (k == 0 || b[3:0] == 4'h5);
                mNeed[k]      = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
            end else begin
                mHasStatus[k] = 0;
            end
        end else if (!mHasStatus[k]) begin
            eErr[k] = 1;
        end else begin
            if (mGot[k] == 0) mD1[k] = b[6:0];
            mGot[k]++;
            if (mGot[k] == mNeed[k]) begin
                if (mIsNote[k]) begin
                    on        = mOnType[k] && (b[6:0] != 0);
                    eValid[k] = 1;
                    eOn[k]    = on;
                    eCh[k]    = mCh[k];
                    eNote[k]  = mD1[k];
                    eVel[k]   = b[6:0];
                    if (on) eLed[k] = {1'b1, mD1[k]};
                    else if (eLed[k] == {1'b1, mD1[k]}) eLed[k] = 8'h00;
                end
                mGot[k] = 0;
`ifndef MIDI_RUNNING_STATUS_EN
                mHasStatus[k] = 0;
`endif
            end
        end
    endtask

    task automatic checkOne(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(input int k);
        checkOne($sformatf("msg_valid[%0d]", k), {7'd0, msgValid[k]}, {7'd0, eValid[k]});
        checkOne($sformatf("note_on[%0d]", k),   {7'd0, noteOn[k]},   {7'd0, eOn[k]});
        checkOne($sformatf("channel[%0d]", k),   {4'd0, channel[k]},  {4'd0, eCh[k]});
        checkOne($sformatf("note[%0d]", k),      {1'b0, note[k]},     {1'b0, eNote[k]});
        checkOne($sformatf("velocity[%0d]", k),  {1'b0, velocity[k]}, {1'b0, eVel[k]});
        checkOne($sformatf("led[%0d]", k),       led[k],              eLed[k]);
        checkOne($sformatf("error[%0d]", k),     {7'd0, error[k]},    {7'd0, eErr[k]});
    endtask

    // Every cycle, away from the active edge, compare both instances to the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput(0);
            checkOutput(1);
        end
    end

    // Drive one cycle of input, then advance the model past the sampling edge.
    task automatic applyStimulus(input bit v, input bit [7:0] b, input bit rst);
        byteValid = v;
        byteIn    = b;
        reset     = rst;
        @(posedge clk);
        modelStep(0, rst, v, b);
        modelStep(1, rst, v, b);
        @(negedge clk);
    endtask

    task automatic sendBytes(input bit [7:0] seq [$]);
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    function automatic bit [7:0] randomByte();
        int r;
        bit [3:0] ch;
        r = $urandom_range(0, 99);
        if (r < 45) begin
            if ($urandom_range(0, 1) == 0) return {1'b0, 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 3) == 0) return 8'h00;
            return 8'($urandom_range(8'h3C, 8'h3F));
        end
        if (r < 75) begin
            case ($urandom_range(0, 2))
                0:       ch = 4'h0;
                1:       ch = 4'h5;
                default: ch = 4'($urandom_range(0, 15));
            endcase
            return {3'b100, 1'($urandom_range(0, 1)), ch};
        end
        if (r < 87) return 8'($urandom_range(8'hA0, 8'hEF));
        if (r < 92) return 8'($urandom_range(8'hF0, 8'hF7));
        return 8'($urandom_range(8'hF8, 8'hFF));
    endfunction

    initial begin
        byteValid = 1'b0;
        byteIn    = 8'h00;
        reset     = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checking = 1;
        checkOne("reset led", led[0], 8'h00);
        checkOne("reset error", {7'd0, error[0]}, 8'h00);

        // Simple Note On.
        sendBytes('{8'h90, 8'h3C, 8'h64});
        checkOne("lit1 valid", {7'd0, msgValid[0]}, 8'h01);
        checkOne("lit1 note", {1'b0, note[0]}, 8'h3C);
        checkOne("lit1 vel", {1'b0, velocity[0]}, 8'h64);
        checkOne("lit1 led", led[0], 8'hBC);
        checkOne("lit1 ch5 filtered", {7'd0, msgValid[1]}, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOne("lit1 pulse width", {7'd0, msgValid[0]}, 8'h00);

        // Note On then matching Note Off on channel 3.
        doReset();
        sendBytes('{8'h93, 8'h40, 8'h7F});
        checkOne("lit2 led on", led[0], 8'hC0);
        sendBytes('{8'h83, 8'h40, 8'h00});
        checkOne("lit2 note_on", {7'd0, noteOn[0]}, 8'h00);
        checkOne("lit2 channel", {4'd0, channel[0]}, 8'h03);
        checkOne("lit2 led off", led[0], 8'h00);

        // Data pair after a completed event.
        doReset();
        sendBytes('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00});
`ifdef MIDI_RUNNING_STATUS_EN
        checkOne("lit3 valid", {7'd0, msgValid[0]}, 8'h01);
        checkOne("lit3 note_on", {7'd0, noteOn[0]}, 8'h00);
        checkOne("lit3 note", {1'b0, note[0]}, 8'h3E);
`else
        checkOne("lit3 valid", {7'd0, msgValid[0]}, 8'h00);
        checkOne("lit3 error", {7'd0, error[0]}, 8'h01);
`endif
        checkOne("lit3 led", led[0], 8'hBC);

        // Real-time byte mid-message.
        doReset();
        sendBytes('{8'h90, 8'h3C, 8'hF8, 8'h64});
        checkOne("lit4 valid", {7'd0, msgValid[0]}, 8'h01);
        checkOne("lit4 led", led[0], 8'hBC);

        // Program change skipped, then a note on channel 5 seen by both instances.
        doReset();
        sendBytes('{8'hC0, 8'h05, 8'h95, 8'h3C, 8'h64});
        checkOne("lit5 valid", {7'd0, msgValid[0]}, 8'h01);
        checkOne("lit5 ch5 valid", {7'd0, msgValid[1]}, 8'h01);
        checkOne("lit5 ch5 channel", {4'd0, channel[1]}, 8'h05);
        checkOne("lit5 error", {7'd0, error[0]}, 8'h00);

        // Reset mid-message.
        doReset();
        sendBytes('{8'h90, 8'h3C});
        applyStimulus(1'b0, 8'h00, 1'b1);
        sendBytes('{8'h64});
        checkOne("lit6 valid", {7'd0, msgValid[0]}, 8'h00);
        checkOne("lit6 error", {7'd0, error[0]}, 8'h01);
        checkOne("lit6 led", led[0], 8'h00);
        checkOne("lit6 note", {1'b0, note[0]}, 8'h00);

        // Randomized stream with occasional gaps and resets.
        doReset();
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 9) < 8, randomByte(), $urandom_range(0, 299) == 0);
        end

        applyStimulus(1'b0, 8'h00, 1'b0);
        checking = 0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
